// File: rtl/fmul32_pack_if.sv
// Valid/ready bundle between the FMUL32 classifier stage, the result packer and the output port.
interface fmul32_pack_if #(
  parameter int unsigned MARK_W = 5
);
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MANT_W = 48;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [MARK_W-1:0] in_mark;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [3:0]        out_flags;

  modport master (output in_valid, in_sign, in_mark, in_exp, in_mant, out_ready,
                  input  in_ready, out_valid, out_data, out_flags);
  modport slave  (input  in_valid, in_sign, in_mark, in_exp, in_mant, out_ready,
                  output in_ready, out_valid, out_data, out_flags);
endinterface

// File: rtl/fmul32_pack.sv
// FMUL32 result packer: normalize, round-to-nearest-even, resolve specials, pack IEEE-754 single.
// Two-stage valid/ready pipeline; stage 2 is the output register.
module fmul32_pack #(
  parameter int unsigned MARK_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  fmul32_pack_if.slave bus
);
  localparam int unsigned EXP_W      = 10;
  localparam int unsigned XEXP_W     = 12;
  localparam int unsigned SIG_W      = 24;
  localparam int unsigned FRAC_W     = SIG_W - 1;
  localparam int unsigned POS_ZERO   = 0;
  localparam int unsigned POS_DENORM = 1;
  localparam int unsigned POS_NORM   = 2;
  localparam int unsigned POS_INF    = 3;
  localparam int unsigned POS_NAN    = 4;

  typedef struct packed {
    logic              sign;
    logic              nan;
    logic              inf;
    logic              zero;
    logic              tiny;
    logic [XEXP_W-1:0] exp;
    logic [SIG_W-1:0]  sig;
    logic              guard;
    logic              sticky;
  } norm_t;

  logic              v1_q, v1_d, v2_q, v2_d;
  norm_t             s1_q, s1_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        flags_q, flags_d;
  logic              adv1_c, in_ready_c, ld1_c, ld2_c;
  logic              arith_c;
  logic [XEXP_W-1:0] exp_in_c;
  logic              round_up_c, carry_c;
  logic [FRAC_W-1:0] frac_c;
  logic [XEXP_W-1:0] exp_rnd_c;

  // Stage 1 may advance whenever stage 2 is empty or draining this cycle.
  assign adv1_c     = !v2_q | bus.out_ready;
  assign in_ready_c = !v1_q | adv1_c;
  assign ld1_c      = bus.in_valid & in_ready_c;
  assign ld2_c      = v1_q & adv1_c;
  assign v1_d       = ld1_c | (v1_q & !adv1_c);
  assign v2_d       = ld2_c | (v2_q & !bus.out_ready);

  // Stage 1: normalize the product; exponent widened so both +1 steps cannot wrap.
  always_comb begin
    s1_d     = s1_q;
    exp_in_c = {{(XEXP_W-EXP_W){bus.in_exp[EXP_W-1]}}, bus.in_exp};
    arith_c  = bus.in_mark[POS_NORM] | bus.in_mark[POS_DENORM] | ~|bus.in_mark;
    if (ld1_c) begin
      s1_d.sign = bus.in_sign;
      s1_d.nan  = bus.in_mark[POS_NAN];
      s1_d.inf  = bus.in_mark[POS_INF];
      s1_d.zero = bus.in_mark[POS_ZERO];
      s1_d.tiny = arith_c & !(bus.in_mant[47] | bus.in_mant[46]);
      if (bus.in_mant[47]) begin
        s1_d.sig    = bus.in_mant[47:24];
        s1_d.guard  = bus.in_mant[23];
        s1_d.sticky = |bus.in_mant[22:0];
        s1_d.exp    = exp_in_c + XEXP_W'(1);
      end else begin
        s1_d.sig    = bus.in_mant[46:23];
        s1_d.guard  = bus.in_mant[22];
        s1_d.sticky = |bus.in_mant[21:0];
        s1_d.exp    = exp_in_c;
      end
    end
  end

  // Stage 2: round, then specials override the arithmetic result in priority order.
  always_comb begin
    data_d     = data_q;
    flags_d    = flags_q;
    round_up_c = s1_q.guard & (s1_q.sticky | s1_q.sig[0]);
    carry_c    = round_up_c & (&s1_q.sig);
    frac_c     = s1_q.sig[FRAC_W-1:0] + FRAC_W'(round_up_c);
    exp_rnd_c  = s1_q.exp + XEXP_W'(carry_c);
    if (ld2_c) begin
      if (s1_q.nan) begin
        data_d  = 32'h7FC0_0000;
        flags_d = 4'b1000;
      end else if (s1_q.inf) begin
        data_d  = {s1_q.sign, 8'hFF, 23'h0};
        flags_d = 4'b0000;
      end else if (s1_q.zero) begin
        data_d  = {s1_q.sign, 31'h0};
        flags_d = 4'b0000;
      end else if (s1_q.tiny || ($signed(exp_rnd_c) <= $signed(XEXP_W'(0)))) begin
        data_d  = {s1_q.sign, 31'h0};
        flags_d = 4'b0011;
      end else if ($signed(exp_rnd_c) >= $signed(XEXP_W'(255))) begin
        data_d  = {s1_q.sign, 8'hFF, 23'h0};
        flags_d = 4'b0101;
      end else begin
        data_d  = {s1_q.sign, exp_rnd_c[7:0], frac_c};
        flags_d = {3'b000, s1_q.guard | s1_q.sticky};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      s1_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      s1_q    <= s1_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v2_q;
  assign bus.out_data  = data_q;
  assign bus.out_flags = flags_q;

endmodule

// File: tb/tb_fmul32_pack.sv
// Directed-vector bench for fmul32_pack: arithmetic, specials, streaming, backpressure, reset.
module tb_fmul32_pack;
  localparam int unsigned N_VEC = 21;

  typedef struct {
    logic        sign;
    logic [4:0]  mark;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic [31:0] data;
    logic [3:0]  flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl [N_VEC];

  fmul32_pack_if #(.MARK_W(5)) bus ();

  fmul32_pack #(.MARK_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic init_tbl();
    tbl[0]  = '{1'b0, 5'h04, 10'd127, 48'h900000000000, 32'h40100000, 4'h0};
    tbl[1]  = '{1'b0, 5'h04, 10'd127, 48'h7FFFFFFFFFFF, 32'h40000000, 4'h1};
    tbl[2]  = '{1'b0, 5'h04, 10'd254, 48'h800000000000, 32'h7F800000, 4'h5};
    tbl[3]  = '{1'b0, 5'h04, 10'h3FB, 48'h400000000000, 32'h00000000, 4'h3};
    tbl[4]  = '{1'b1, 5'h04, 10'h3FB, 48'h400000000000, 32'h80000000, 4'h3};
    tbl[5]  = '{1'b1, 5'h04, 10'd127, 48'h200000000000, 32'h80000000, 4'h3};
    tbl[6]  = '{1'b0, 5'h04, 10'd0,   48'h800000000000, 32'h00800000, 4'h0};
    tbl[7]  = '{1'b0, 5'h04, 10'd0,   48'h400000000000, 32'h00000000, 4'h3};
    tbl[8]  = '{1'b0, 5'h04, 10'd127, 48'h400000400000, 32'h3F800000, 4'h1};
    tbl[9]  = '{1'b0, 5'h04, 10'd127, 48'h400000C00000, 32'h3F800002, 4'h1};
    tbl[10] = '{1'b1, 5'h00, 10'd127, 48'h900000000000, 32'hC0100000, 4'h0};
    tbl[11] = '{1'b0, 5'h02, 10'd253, 48'h800000000000, 32'h7F000000, 4'h0};
    tbl[12] = '{1'b0, 5'h04, 10'd253, 48'hFFFFFFFFFFFF, 32'h7F800000, 4'h5};
    tbl[13] = '{1'b0, 5'h04, 10'h1FF, 48'h800000000000, 32'h7F800000, 4'h5};
    tbl[14] = '{1'b0, 5'h04, 10'h200, 48'h400000000000, 32'h00000000, 4'h3};
    tbl[15] = '{1'b1, 5'h10, 10'd0,   48'h000000000000, 32'h7FC00000, 4'h8};
    tbl[16] = '{1'b1, 5'h08, 10'd0,   48'h000000000000, 32'hFF800000, 4'h0};
    tbl[17] = '{1'b1, 5'h01, 10'd0,   48'h000000000000, 32'h80000000, 4'h0};
    tbl[18] = '{1'b0, 5'h18, 10'd127, 48'h900000000000, 32'h7FC00000, 4'h8};
    tbl[19] = '{1'b0, 5'h0C, 10'd127, 48'h900000000000, 32'h7F800000, 4'h0};
    tbl[20] = '{1'b1, 5'h05, 10'd127, 48'h900000000000, 32'h80000000, 4'h0};
  endtask

  task automatic drive_beat(input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_sign  = v.sign;
    bus.in_mark  = v.mark;
    bus.in_exp   = v.exp;
    bus.in_mant  = v.mant;
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_mark  = '0;
    bus.in_exp   = '0;
    bus.in_mant  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", bus.out_data); end
    checks++;
    if (bus.out_flags !== 4'h0) begin failures++; $display("FAIL reset_flags: got %b expected 0000", bus.out_flags); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_arith();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive_beat(tbl[i]);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL arith_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      @(negedge clk);
      drive_idle();
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arith_early_valid[%0d]: got %b expected 0", i, bus.out_valid); end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL arith_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++;
      if (bus.out_data !== tbl[i].data) begin failures++; $display("FAIL arith_data[%0d]: got %h expected %h", i, bus.out_data, tbl[i].data); end
      checks++;
      if (bus.out_flags !== tbl[i].flags) begin failures++; $display("FAIL arith_flags[%0d]: got %b expected %b", i, bus.out_flags, tbl[i].flags); end
    end
  endtask

  task automatic test_specials();
    bus.out_ready = 1'b1;
    for (int i = 15; i < N_VEC; i++) begin
      @(negedge clk);
      drive_beat(tbl[i]);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL special_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++;
      if (bus.out_data !== tbl[i].data) begin failures++; $display("FAIL special_data[%0d]: got %h expected %h", i, bus.out_data, tbl[i].data); end
      checks++;
      if (bus.out_flags !== tbl[i].flags) begin failures++; $display("FAIL special_flags[%0d]: got %b expected %b", i, bus.out_flags, tbl[i].flags); end
    end
  endtask

  task automatic test_back_to_back();
    int sel [4] = '{8, 9, 10, 11};
    int got = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) drive_beat(tbl[sel[c]]); else drive_idle();
      #1;
      if (c < 4) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, bus.in_ready); end
      end
      checks++;
      if (bus.out_valid !== ((c >= 2) && (c < 6))) begin
        failures++; $display("FAIL b2b_valid[%0d]: got %b expected %b", c, bus.out_valid, (c >= 2) && (c < 6));
      end
      if (bus.out_valid === 1'b1 && got < 4) begin
        checks++;
        if (bus.out_data !== tbl[sel[got]].data || bus.out_flags !== tbl[sel[got]].flags) begin
          failures++;
          $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", got, bus.out_data, bus.out_flags, tbl[sel[got]].data, tbl[sel[got]].flags);
        end
        got++;
      end
    end
    checks++;
    if (got != 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", got); end
  endtask

  task automatic test_backpressure();
    int sel [4] = '{0, 1, 15, 6};
    int idx = 0;
    int got = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (idx < 4) drive_beat(tbl[sel[idx]]); else drive_idle();
      #1;
      checks++;
      if (bus.in_ready !== (c < 2)) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", c, bus.in_ready, c < 2); end
      if (c >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== tbl[sel[0]].data || bus.out_flags !== tbl[sel[0]].flags) begin
          failures++;
          $display("FAIL bp_hold[%0d]: got v=%b %h/%b expected v=1 %h/%b", c, bus.out_valid, bus.out_data, bus.out_flags, tbl[sel[0]].data, tbl[sel[0]].flags);
        end
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    checks++;
    if (idx != 2) begin failures++; $display("FAIL bp_accepts: got %0d expected 2", idx); end
    for (int c = 0; c < 12 && got < 4; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (idx < 4) drive_beat(tbl[sel[idx]]); else drive_idle();
      #1;
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.out_data !== tbl[sel[got]].data || bus.out_flags !== tbl[sel[got]].flags) begin
          failures++;
          $display("FAIL bp_order[%0d]: got %h/%b expected %h/%b", got, bus.out_data, bus.out_flags, tbl[sel[got]].data, tbl[sel[got]].flags);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    checks++;
    if (got != 4) begin failures++; $display("FAIL bp_drain_count: got %0d expected 4", got); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_in_flight();
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive_beat(tbl[0]);
    @(negedge clk);
    drive_beat(tbl[1]);
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rif_loaded: got %b expected 1", bus.out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rif_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_flags !== 4'h0) begin
      failures++; $display("FAIL rif_outputs: got %h/%b expected 00000000/0000", bus.out_data, bus.out_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rif_stale: got %b expected 0", bus.out_valid); end
    drive_beat(tbl[9]);
    @(negedge clk);
    drive_idle();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rif_early: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== tbl[9].data || bus.out_flags !== tbl[9].flags) begin
      failures++; $display("FAIL rif_new_result: got v=%b %h/%b expected v=1 %h/%b", bus.out_valid, bus.out_data, bus.out_flags, tbl[9].data, tbl[9].flags);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rif_after: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_arith();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
